alu_writeback: RTL and testbench

ALU_WRITEBACK -- requirements
Module: alu_writeback

---
 rtl/alu_writeback.sv | 124 ++++++++++++
 tb/tb_alu_writeback.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback.sv
// ALU result writeback: DEPTH-entry {rd,data} queue to the register file, arch flags register, forwarding lookup.
// Latency 1 (no bypass); in_ready = !full, stalls while the register file withholds rf_ready.
module alu_writeback #(
   parameter int DATA_W = 32,
   parameter int RA_W   = 5,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_result,
   input  logic [7:0]        in_flags,
   input  logic [3:0]        in_op,
   input  logic [RA_W-1:0]   in_rd,
   input  logic              in_wr,
   output logic              rf_we,
   output logic [RA_W-1:0]   rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   input  logic              rf_ready,
   output logic [7:0]        flags_q,
   input  logic              sw_flags_we,
   input  logic [7:0]        sw_flags,
   input  logic [RA_W-1:0]   fwd_rd,
   output logic              fwd_hit,
   output logic [DATA_W-1:0] fwd_data,
   output logic [31:0]       retired
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [3:0] OP_CMP = 4'hC;

   logic [RA_W-1:0]   rd_mem_q   [DEPTH];
   logic [RA_W-1:0]   rd_mem_d   [DEPTH];
   logic [DATA_W-1:0] data_mem_q [DEPTH];
   logic [DATA_W-1:0] data_mem_d [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [31:0]       retired_q, retired_d;
   logic [7:0]        flags_d;

   logic full, empty, accept, enq, deq;
   logic [PW-1:0] idx;

   // Upper ALU flag bits are architecturally owned by software, never by the ALU.
   logic unused_in_flags;
   assign unused_in_flags = ^in_flags[7:4];

   assign full     = (count_q == CW'(DEPTH));
   assign empty    = (count_q == '0);
   assign accept   = in_valid && !full;
   assign enq      = accept && in_wr && (in_op != OP_CMP) && (in_rd != '0);
   assign deq      = !empty && rf_ready;

   assign in_ready = !full;
   assign rf_we    = !empty;
   assign rf_waddr = empty ? '0 : rd_mem_q[rd_ptr_q];
   assign rf_wdata = empty ? '0 : data_mem_q[rd_ptr_q];
   assign retired  = retired_q;

   always_comb begin
      rd_mem_d   = rd_mem_q;
      data_mem_d = data_mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      retired_d  = retired_q;
      flags_d    = flags_q;
      if (enq) begin
         rd_mem_d[wr_ptr_q]   = in_rd;
         data_mem_d[wr_ptr_q] = in_result;
         wr_ptr_d             = wr_ptr_q + PW'(1);
      end
      if (deq) begin
         rd_ptr_d  = rd_ptr_q + PW'(1);
         retired_d = retired_q + 32'd1;
      end
      case ({enq, deq})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      // Software load first so an ALU accept in the same cycle owns the low nibble.
      if (sw_flags_we) flags_d = sw_flags;
      if (accept)      flags_d[3:0] = in_flags[3:0];
   end

   // Walk oldest to youngest so the last match is the youngest producer.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      idx      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr_q + PW'(i);
         if ((CW'(i) < count_q) && (fwd_rd != '0) && (rd_mem_q[idx] == fwd_rd)) begin
            fwd_hit  = 1'b1;
            fwd_data = data_mem_q[idx];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            rd_mem_q[i]   <= '0;
            data_mem_q[i] <= '0;
         end
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         retired_q <= '0;
         flags_q   <= '0;
      end else begin
         rd_mem_q   <= rd_mem_d;
         data_mem_q <= data_mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         retired_q  <= retired_d;
         flags_q    <= flags_d;
      end
   end
endmodule

// File: tb/tb_alu_writeback.sv
// Bench for alu_writeback: directed vector table, hand sequences, random traffic against a queue scoreboard.
module tb_alu_writeback;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, in_wr, rf_we, rf_ready, sw_flags_we, fwd_hit;
   logic [31:0] in_result, rf_wdata, fwd_data, retired;
   logic [7:0]  in_flags, flags_q, sw_flags;
   logic [3:0]  in_op;
   logic [4:0]  in_rd, rf_waddr, fwd_rd;

   int total = 0;
   int bad   = 0;

   alu_writeback dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_flags(in_flags),
      .in_op(in_op), .in_rd(in_rd), .in_wr(in_wr),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_ready(rf_ready),
      .flags_q(flags_q), .sw_flags_we(sw_flags_we), .sw_flags(sw_flags),
      .fwd_rd(fwd_rd), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .retired(retired)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: expected register writes queued on accept, compared as the DUT presents them.
   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;
   ent_t        mq[$];
   logic [7:0]  m_flags;
   logic [31:0] m_ret;

   always @(negedge clk) begin
      if (rst) begin
         mq.delete();
         m_flags = 8'h00;
         m_ret   = 32'd0;
      end else begin
         logic        exp_rdy, exp_hit;
         logic [31:0] exp_fd;
         exp_rdy = (mq.size() < 2);
         exp_hit = 1'b0;
         exp_fd  = 32'd0;
         foreach (mq[i]) if (fwd_rd != 5'd0 && mq[i].rd == fwd_rd) begin
            exp_hit = 1'b1;
            exp_fd  = mq[i].data;
         end
         chk("sb_in_ready", in_ready, exp_rdy);
         chk("sb_rf_we", rf_we, mq.size() != 0);
         chk("sb_flags", flags_q, m_flags);
         chk("sb_retired", retired, m_ret);
         chk("sb_fwd_hit", fwd_hit, exp_hit);
         chk("sb_fwd_data", fwd_data, exp_fd);
         if (mq.size() != 0) begin
            chk("sb_rf_waddr", rf_waddr, mq[0].rd);
            chk("sb_rf_wdata", rf_wdata, mq[0].data);
            if (rf_ready) begin
               void'(mq.pop_front());
               m_ret++;
            end
         end else begin
            chk("sb_rf_waddr_idle", rf_waddr, 0);
            chk("sb_rf_wdata_idle", rf_wdata, 0);
         end
         if (in_valid && exp_rdy && in_wr && in_op != 4'hC && in_rd != 5'd0) begin
            ent_t e;
            e.rd   = in_rd;
            e.data = in_result;
            mq.push_back(e);
         end
         if (sw_flags_we) m_flags = sw_flags;
         if (in_valid && exp_rdy) m_flags[3:0] = in_flags[3:0];
      end
   end

   typedef struct {
      logic vld; logic wr; logic [3:0] op; logic [4:0] rd; logic [31:0] res; logic [7:0] fl;
      logic rdy; logic swe; logic [7:0] swf; logic [4:0] frd;
      logic e_irdy; logic e_we; logic [4:0] e_addr; logic [31:0] e_data; logic [7:0] e_flags;
      logic [31:0] e_ret; logic e_hit; logic [31:0] e_fdata;
   } vec_t;
   vec_t vt[13];

   function automatic vec_t mk(logic vld, logic wr, logic [3:0] op, logic [4:0] rd, logic [31:0] res,
                               logic [7:0] fl, logic rdy, logic swe, logic [7:0] swf, logic [4:0] frd,
                               logic e_irdy, logic e_we, logic [4:0] e_addr, logic [31:0] e_data,
                               logic [7:0] e_flags, logic [31:0] e_ret, logic e_hit, logic [31:0] e_fdata);
      vec_t v;
      v.vld = vld; v.wr = wr; v.op = op; v.rd = rd; v.res = res; v.fl = fl;
      v.rdy = rdy; v.swe = swe; v.swf = swf; v.frd = frd;
      v.e_irdy = e_irdy; v.e_we = e_we; v.e_addr = e_addr; v.e_data = e_data;
      v.e_flags = e_flags; v.e_ret = e_ret; v.e_hit = e_hit; v.e_fdata = e_fdata;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic vld, input logic wr, input logic [3:0] op, input logic [4:0] rd,
                        input logic [31:0] res, input logic [7:0] fl, input logic rdy);
      in_valid = vld; in_wr = wr; in_op = op; in_rd = rd; in_result = res; in_flags = fl; rf_ready = rdy;
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 1'b0, 4'h0, 5'd0, 32'd0, 8'h00, 1'b0);
      sw_flags_we = 1'b0; sw_flags = 8'h00; fwd_rd = 5'd0;

      //         vld wr op    rd     res            fl     rdy swe swf    frd  | irdy we addr  data           flags ret    hit fdata
      vt[0]  = mk(1, 1, 4'h0, 5'd3, 32'h12345678, 8'h03, 1, 0, 8'h00, 5'd3, 1, 1, 5'd3, 32'h12345678, 8'h03, 32'd0, 1, 32'h12345678);
      vt[1]  = mk(0, 0, 4'h0, 5'd0, 32'h0,        8'h00, 1, 0, 8'h00, 5'd3, 1, 0, 5'd0, 32'h0,        8'h03, 32'd1, 0, 32'h0);
      vt[2]  = mk(1, 1, 4'hC, 5'd4, 32'h99,       8'h06, 1, 0, 8'h00, 5'd4, 1, 0, 5'd0, 32'h0,        8'h06, 32'd1, 0, 32'h0);
      vt[3]  = mk(0, 0, 4'h0, 5'd0, 32'h0,        8'h00, 1, 0, 8'h00, 5'd4, 1, 0, 5'd0, 32'h0,        8'h06, 32'd1, 0, 32'h0);
      vt[4]  = mk(1, 1, 4'h1, 5'd5, 32'hA,        8'h00, 0, 0, 8'h00, 5'd5, 1, 1, 5'd5, 32'hA,        8'h00, 32'd1, 1, 32'hA);
      vt[5]  = mk(1, 1, 4'h2, 5'd5, 32'hB,        8'h00, 0, 0, 8'h00, 5'd5, 0, 1, 5'd5, 32'hA,        8'h00, 32'd1, 1, 32'hB);
      vt[6]  = mk(0, 0, 4'h0, 5'd0, 32'h0,        8'h00, 0, 0, 8'h00, 5'd0, 0, 1, 5'd5, 32'hA,        8'h00, 32'd1, 0, 32'h0);
      vt[7]  = mk(0, 0, 4'h0, 5'd0, 32'h0,        8'h00, 1, 0, 8'h00, 5'd5, 1, 1, 5'd5, 32'hB,        8'h00, 32'd2, 1, 32'hB);
      vt[8]  = mk(0, 0, 4'h0, 5'd0, 32'h0,        8'h00, 1, 0, 8'h00, 5'd5, 1, 0, 5'd0, 32'h0,        8'h00, 32'd3, 0, 32'h0);
      vt[9]  = mk(1, 0, 4'h0, 5'd7, 32'hDEAD,     8'h01, 1, 1, 8'h30, 5'd7, 1, 0, 5'd0, 32'h0,        8'h31, 32'd3, 0, 32'h0);
      vt[10] = mk(0, 0, 4'h0, 5'd0, 32'h0,        8'h00, 1, 1, 8'hA5, 5'd0, 1, 0, 5'd0, 32'h0,        8'hA5, 32'd3, 0, 32'h0);
      vt[11] = mk(1, 1, 4'h0, 5'd0, 32'hBEEF,     8'hFF, 1, 0, 8'h00, 5'd0, 1, 0, 5'd0, 32'h0,        8'hAF, 32'd3, 0, 32'h0);
      vt[12] = mk(0, 0, 4'h0, 5'd0, 32'h0,        8'h00, 0, 0, 8'h00, 5'd0, 1, 0, 5'd0, 32'h0,        8'hAF, 32'd3, 0, 32'h0);

      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("reset_in_ready", in_ready, 1);
      chk("reset_rf_we", rf_we, 0);
      chk("reset_fwd_hit", fwd_hit, 0);
      chk("reset_flags", flags_q, 8'h00);
      chk("reset_retired", retired, 0);

      for (int i = 0; i < 13; i++) begin
         drive(vt[i].vld, vt[i].wr, vt[i].op, vt[i].rd, vt[i].res, vt[i].fl, vt[i].rdy);
         sw_flags_we = vt[i].swe; sw_flags = vt[i].swf; fwd_rd = vt[i].frd;
         tick();
         chk($sformatf("vec%0d_in_ready", i), in_ready, vt[i].e_irdy);
         chk($sformatf("vec%0d_rf_we", i), rf_we, vt[i].e_we);
         chk($sformatf("vec%0d_rf_waddr", i), rf_waddr, vt[i].e_addr);
         chk($sformatf("vec%0d_rf_wdata", i), rf_wdata, vt[i].e_data);
         chk($sformatf("vec%0d_flags", i), flags_q, vt[i].e_flags);
         chk($sformatf("vec%0d_retired", i), retired, vt[i].e_ret);
         chk($sformatf("vec%0d_fwd_hit", i), fwd_hit, vt[i].e_hit);
         chk($sformatf("vec%0d_fwd_data", i), fwd_data, vt[i].e_fdata);
      end
      sw_flags_we = 1'b0;

      // Stall with a full queue, then drain in order while the held third entry gets in.
      drive(1'b1, 1'b1, 4'h0, 5'd1, 32'h111, 8'h00, 1'b0); tick();
      drive(1'b1, 1'b1, 4'h0, 5'd2, 32'h222, 8'h00, 1'b0); tick();
      chk("stall_in_ready_full", in_ready, 0);
      drive(1'b1, 1'b1, 4'h0, 5'd6, 32'h333, 8'h00, 1'b0); tick();
      chk("stall_in_ready_held", in_ready, 0);
      chk("stall_head", rf_waddr, 5'd1);
      rf_ready = 1'b1; tick();
      chk("drain_head2", rf_waddr, 5'd2);
      chk("drain_retired1", retired, 32'd4);
      tick();
      in_valid = 1'b0;
      chk("drain_head6", rf_waddr, 5'd6);
      chk("drain_data6", rf_wdata, 32'h333);
      tick();
      chk("drain_empty", rf_we, 0);
      chk("drain_retired3", retired, 32'd6);

      // Reset with a full queue, competing accept, dequeue and software flag load.
      drive(1'b1, 1'b1, 4'h0, 5'd9, 32'h999, 8'h0F, 1'b0); tick();
      drive(1'b1, 1'b1, 4'h0, 5'd10, 32'hAAA, 8'h0F, 1'b0); tick();
      chk("prerst_full", in_ready, 0);
      rst = 1'b1; rf_ready = 1'b1; sw_flags_we = 1'b1; sw_flags = 8'hFF; fwd_rd = 5'd9;
      tick();
      rst = 1'b0; in_valid = 1'b0; rf_ready = 1'b0; sw_flags_we = 1'b0;
      chk("rst_rf_we", rf_we, 0);
      chk("rst_retired", retired, 0);
      chk("rst_flags", flags_q, 8'h00);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_fwd_hit", fwd_hit, 0);
      tick();

      for (int c = 0; c < 400; c++) begin
         drive($urandom_range(0, 2) != 0, $urandom_range(0, 4) != 0,
               ($urandom_range(0, 3) == 0) ? 4'hC : 4'($urandom_range(0, 11)),
               5'($urandom_range(0, 7)), $urandom, 8'($urandom), $urandom_range(0, 2) == 0);
         sw_flags_we = ($urandom_range(0, 9) == 0);
         sw_flags    = 8'($urandom);
         fwd_rd      = 5'($urandom_range(0, 7));
         tick();
      end
      in_valid = 1'b0; sw_flags_we = 1'b0; rf_ready = 1'b1;
      repeat (4) tick();
      chk("final_empty", rf_we, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
